// File: rtl/plat_pkg.sv
// Purpose : shared constants, types and the respawn-X helper for the
//           platform field (producer side of the doodle-jump platform bus).
// Contents: screen geometry, layout/scroll constants, plat_state_t FSM
//           encoding, coord_t screen coordinate, rand_x() respawn position.
package plat_pkg;

  localparam int NUM_PLATS    = 16;
  localparam int SCREEN_H     = 480;
  localparam int SCREEN_Y_MAX = 479;
  localparam int SCROLL_LINE  = 200;
  localparam int MAX_SCROLL   = 8;
  localparam int SPACING      = 30;
  localparam int X_MIN        = 60;
  localparam int X_RANGE      = 440;
  localparam int PLAT_HALF    = 16;
  localparam int X_RESET      = 320;
  localparam int Y_FILL_BASE  = 465;

  typedef enum logic [1:0] {IDLE, FILL, RUN} plat_state_t;

  typedef logic [9:0] coord_t;

  // Folds a 9-bit pseudo-random value into [X_MIN, X_MIN+X_RANGE-1].
  // Mixing in idx*37 keeps slots that respawn in the same frame apart;
  // the product is deliberately truncated to 9 bits. A 9-bit value is
  // below 2*X_RANGE, so one conditional subtract always lands in range.
  function automatic coord_t rand_x(input logic [15:0] lfsr, input logic [3:0] idx);
    logic [8:0] idx9;
    logic [8:0] mix;
    logic [8:0] r;
    idx9 = {5'b0, idx};
    mix  = idx9 * 9'd37;
    r    = lfsr[8:0] ^ mix;
    if (r >= 9'(X_RANGE)) r = r - 9'(X_RANGE);
    return coord_t'(X_MIN) + {1'b0, r};
  endfunction

endpackage

// File: rtl/plat_lfsr.sv
// Purpose : free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that
//           supplies the respawn X randomness; advances every frame.
// Ports   : frame_clk - frame-rate clock
//           Reset     - asynchronous, active-high; loads SEED
//           value     - current LFSR state
module plat_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] value
);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) value <= SEED;
    else       value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  end

endmodule

// File: rtl/platform_field.sv
// Purpose : builds a 16-platform layout on a loadplat rising edge (one slot
//           per frame), then scrolls all platforms down while the doodle
//           climbs above the scroll line, respawning platforms that leave
//           the bottom of the screen, and accumulates the height score.
// Ports   : frame_clk       - frame-rate clock (one tick per VSYNC)
//           Reset           - asynchronous, active-high
//           loadplat        - rebuild request level; rising edge acts
//           doodle_y        - doodle centre Y (screen pixels)
//           doodle_y_motion - doodle Y velocity, two's complement
//           plat_x/plat_y   - per-slot platform centre
//           plat_size       - platform half-width (constant)
//           plats_valid     - layout complete, collisions allowed
//           scroll_amt      - pixels scrolled in the last frame
//           score           - saturating sum of scrolled pixels
module platform_field
  import plat_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic                        loadplat,
  input  logic [9:0]                  doodle_y,
  input  logic [9:0]                  doodle_y_motion,
  output coord_t [NUM_PLATS-1:0]      plat_x,
  output coord_t [NUM_PLATS-1:0]      plat_y,
  output logic [8:0]                  plat_size,
  output logic                        plats_valid,
  output logic [9:0]                  scroll_amt,
  output logic [15:0]                 score
);

  plat_state_t state;
  logic [3:0]  idx;
  logic        load_prev;
  logic        load_edge;
  logic [15:0] lfsr;
  logic [9:0]  amt;
  logic [9:0]  gap;
  logic [16:0] score_sum;
  logic [15:0] score_next;
  coord_t      x_nxt [NUM_PLATS];
  coord_t      y_nxt [NUM_PLATS];

  // Only the sign of the velocity matters for scrolling.
  logic unused_motion;
  assign unused_motion = ^doodle_y_motion[8:0];

  assign plat_size = 9'(PLAT_HALF);
  assign load_edge = loadplat & ~load_prev;

  plat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .value     (lfsr)
  );

  // Scroll only while the doodle is above the line and still rising,
  // by the distance past the line, capped per frame.
  always_comb begin
    amt = '0;
    gap = 10'(SCROLL_LINE) - doodle_y;
    if (doodle_y < 10'(SCROLL_LINE) && doodle_y_motion[9])
      amt = (gap > 10'(MAX_SCROLL)) ? 10'(MAX_SCROLL) : gap;
  end

  assign score_sum  = {1'b0, score} + {7'b0, amt};
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Per-slot next position: written when FILL reaches this slot, moved
  // (and possibly respawned) in RUN, otherwise held.
  for (genvar i = 0; i < NUM_PLATS; i++) begin : g_slot
    logic [10:0] y_sum;
    logic        fill_hit;
    logic        wrap;
    coord_t      x_rand;
    coord_t      fill_x;

    assign y_sum    = {1'b0, plat_y[i]} + {1'b0, amt};
    assign fill_hit = (state == FILL) && (idx == 4'(i));
    assign wrap     = (state == RUN) && (y_sum > 11'(SCREEN_Y_MAX));
    assign x_rand   = rand_x(lfsr, 4'(i));
    assign fill_x   = (i == 0) ? coord_t'(X_RESET) : x_rand;

    assign x_nxt[i] = fill_hit ? fill_x : (wrap ? x_rand : plat_x[i]);
    assign y_nxt[i] = fill_hit        ? coord_t'(Y_FILL_BASE - SPACING * i) :
                      wrap            ? coord_t'(y_sum - 11'(SCREEN_H)) :
                      (state == RUN)  ? y_sum[9:0] : plat_y[i];
  end

  // Layout FSM. A loadplat edge wins over everything else in its frame
  // and leaves positions untouched until FILL rewrites them.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      idx         <= '0;
      load_prev   <= 1'b0;
      plats_valid <= 1'b0;
      scroll_amt  <= '0;
      score       <= '0;
      plat_x      <= {NUM_PLATS{coord_t'(X_RESET)}};
      plat_y      <= '0;
    end else begin
      load_prev <= loadplat;
      if (load_edge) begin
        state       <= FILL;
        idx         <= '0;
        score       <= '0;
        plats_valid <= 1'b0;
        scroll_amt  <= '0;
      end else begin
        case (state)
          FILL: begin
            for (int i = 0; i < NUM_PLATS; i++) begin
              plat_x[i] <= x_nxt[i];
              plat_y[i] <= y_nxt[i];
            end
            scroll_amt <= '0;
            idx        <= idx + 4'd1;
            if (idx == 4'(NUM_PLATS - 1)) begin
              state       <= RUN;
              plats_valid <= 1'b1;
            end
          end
          RUN: begin
            for (int i = 0; i < NUM_PLATS; i++) begin
              plat_x[i] <= x_nxt[i];
              plat_y[i] <= y_nxt[i];
            end
            scroll_amt <= amt;
            score      <= score_next;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_platform_field.sv
// Purpose : self-checking bench for platform_field: reset values, idle hold,
//           layout fill, a table of scroll vectors, reload mid-run, reset
//           mid-fill and mid-run, and score saturation.
module tb_platform_field;
  import plat_pkg::*;

  logic                   frame_clk;
  logic                   Reset;
  logic                   loadplat;
  logic [9:0]             doodle_y;
  logic [9:0]             doodle_y_motion;
  coord_t [15:0]          plat_x;
  coord_t [15:0]          plat_y;
  logic [8:0]             plat_size;
  logic                   plats_valid;
  logic [9:0]             scroll_amt;
  logic [15:0]            score;

  platform_field dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .loadplat        (loadplat),
    .doodle_y        (doodle_y),
    .doodle_y_motion (doodle_y_motion),
    .plat_x          (plat_x),
    .plat_y          (plat_y),
    .plat_size       (plat_size),
    .plats_valid     (plats_valid),
    .scroll_amt      (scroll_amt),
    .score           (score)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [9:0] dy;
    logic [9:0] motion;
    int         amt;
  } vec_t;

  vec_t        vecs [11];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_pre;
  int          ex [16];
  int          ey [16];
  int          escore;

  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int randX(input logic [15:0] l, input int i);
    int p;
    int r;
    logic [8:0] p9;
    p  = i * 37;
    p9 = p[8:0] ^ l[8:0];
    r  = int'(p9);
    if (r >= 440) r = r - 440;
    return 60 + r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkSlots(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 16; i++)
      if (bad < 0 && (int'(plat_x[i]) != ex[i] || int'(plat_y[i]) != ey[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s: slot %0d got (%0d,%0d), expected (%0d,%0d)", name, bad,
               plat_x[bad], plat_y[bad], ex[bad], ey[bad]);
    end
  endtask

  task automatic checkRange(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 16; i++)
      if (bad < 0 && (plat_x[i] < 10'd60 || plat_x[i] > 10'd499)) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s: slot %0d x got %0d, expected within 60..499", name, bad, plat_x[bad]);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] dy, input logic [9:0] motion, input logic load);
    doodle_y        = dy;
    doodle_y_motion = motion;
    loadplat        = load;
  endtask

  // Advances one frame and keeps the reference LFSR in step with the DUT;
  // lfsr_pre holds the value the DUT used at that edge.
  task automatic stepFrame();
    lfsr_pre = lfsr_m;
    @(posedge frame_clk);
    #1;
    if (Reset) lfsr_m = 16'hACE1;
    else       lfsr_m = lfsrNext(lfsr_m);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      ex[i] = 320;
      ey[i] = 0;
    end
    escore = 0;
  endtask

  task automatic modelScroll(input int amt);
    int y;
    for (int i = 0; i < 16; i++) begin
      y = ey[i] + amt;
      if (y > 479) begin
        ey[i] = y - 480;
        ex[i] = randX(lfsr_pre, i);
      end else begin
        ey[i] = y;
      end
    end
    escore = (escore + amt > 65535) ? 65535 : escore + amt;
  endtask

  task automatic doReset(input string name);
    Reset    = 1'b1;
    loadplat = 1'b0;
    #1;
    lfsr_m = 16'hACE1;
    modelReset();
    checkSlots({name, "_slots"});
    checkOutput({name, "_valid"}, int'(plats_valid), 0);
    checkOutput({name, "_scroll"}, int'(scroll_amt), 0);
    checkOutput({name, "_score"}, int'(score), 0);
    checkOutput({name, "_size"}, int'(plat_size), 16);
    stepFrame();
    Reset = 1'b0;
  endtask

  // Loadplat edge, then 16 fill frames with scroll inputs active to show
  // that nothing scrolls while the layout is being written.
  task automatic doFill(input string name);
    int early;
    applyStimulus(10'd150, 10'h3FD, 1'b1);
    stepFrame();
    escore = 0;
    checkOutput({name, "_edge_valid"}, int'(plats_valid), 0);
    checkOutput({name, "_edge_score"}, int'(score), 0);
    early = 0;
    for (int k = 0; k < 16; k++) begin
      stepFrame();
      ex[k] = (k == 0) ? 320 : randX(lfsr_pre, k);
      ey[k] = 465 - 30 * k;
      if (k < 15 && plats_valid !== 1'b0) early++;
    end
    checkOutput({name, "_valid_early"}, early, 0);
    checkOutput({name, "_valid"}, int'(plats_valid), 1);
    checkOutput({name, "_scroll"}, int'(scroll_amt), 0);
    checkOutput({name, "_slot0_x"}, int'(plat_x[0]), 320);
    checkOutput({name, "_slot0_y"}, int'(plat_y[0]), 465);
    checkOutput({name, "_slot15_y"}, int'(plat_y[15]), 15);
    checkRange({name, "_xrange"});
    checkSlots({name, "_slots"});
  endtask

  initial begin
    vecs[0]  = '{10'd150, 10'h3FD, 8};
    vecs[1]  = '{10'd196, 10'h3FD, 4};
    vecs[2]  = '{10'd150, 10'd3,   0};
    vecs[3]  = '{10'd150, 10'd0,   0};
    vecs[4]  = '{10'd199, 10'h3FF, 1};
    vecs[5]  = '{10'd200, 10'h3FB, 0};
    vecs[6]  = '{10'd192, 10'h3FE, 8};
    vecs[7]  = '{10'd193, 10'h3FE, 7};
    vecs[8]  = '{10'd0,   10'h3FF, 8};
    vecs[9]  = '{10'd150, 10'h200, 8};
    vecs[10] = '{10'd250, 10'h3FD, 0};

    Reset  = 1'b0;
    lfsr_m = 16'hACE1;
    modelReset();
    applyStimulus(10'd300, 10'd0, 1'b0);
    #1;
    doReset("reset_init");

    // Idle must ignore scroll inputs.
    applyStimulus(10'd150, 10'h3FD, 1'b0);
    for (int k = 0; k < 3; k++) stepFrame();
    checkOutput("idle_scroll", int'(scroll_amt), 0);
    checkOutput("idle_valid", int'(plats_valid), 0);
    checkSlots("idle_slots");

    doFill("fill1");

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].dy, vecs[v].motion, 1'b1);
      stepFrame();
      modelScroll(vecs[v].amt);
      checkOutput($sformatf("run%0d_scroll", v), int'(scroll_amt), vecs[v].amt);
      checkSlots($sformatf("run%0d_slots", v));
      checkOutput($sformatf("run%0d_score", v), int'(score), escore);
    end
    checkRange("run_xrange");

    // Reload during RUN; the edge frame must not scroll.
    applyStimulus(10'd300, 10'd0, 1'b0);
    stepFrame();
    modelScroll(0);
    applyStimulus(10'd150, 10'h3FD, 1'b1);
    stepFrame();
    escore = 0;
    checkOutput("reload_valid", int'(plats_valid), 0);
    checkOutput("reload_score", int'(score), 0);
    checkOutput("reload_scroll", int'(scroll_amt), 0);
    checkSlots("reload_slots");
    for (int k = 0; k < 7; k++) begin
      stepFrame();
      ex[k] = (k == 0) ? 320 : randX(lfsr_pre, k);
      ey[k] = 465 - 30 * k;
    end
    checkSlots("refill_partial");
    doReset("reset_fill");

    applyStimulus(10'd150, 10'h3FD, 1'b0);
    for (int k = 0; k < 2; k++) stepFrame();
    checkOutput("post_reset_valid", int'(plats_valid), 0);
    checkSlots("post_reset_slots");

    doFill("fill2");

    // Long climb to drive the score into saturation.
    applyStimulus(10'd150, 10'h3FD, 1'b1);
    for (int k = 0; k < 8200; k++) begin
      stepFrame();
      modelScroll(8);
    end
    checkOutput("sat_score", int'(score), 65535);
    checkOutput("sat_scroll", int'(scroll_amt), 8);
    checkSlots("sat_slots");
    doReset("reset_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
